// File: rtl/asymmetric_pack_buffer_if.sv
// Narrow-in / wide-out stream bundle for the asymmetric pack buffer.
interface asymmetric_pack_buffer_if #(
  parameter int WIDTHA = 4,
  parameter int WIDTHB = 16
);
  logic [WIDTHA-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [WIDTHB-1:0] out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/asymmetric_pack_buffer.sv
// Packs WIDTHA-bit elements little-endian into WIDTHB-bit words, buffers them
// in a DEPTHB-word RAM and issues them through a two-stage registered read path.
module asymmetric_pack_buffer #(
  parameter int WIDTHA    = 4,
  parameter int WIDTHB    = 16,
  parameter int DEPTHB    = 256,
  parameter     RAM_STYLE = "auto"
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  asymmetric_pack_buffer_if.slave bus
);
  localparam int RATIO = WIDTHB / WIDTHA;
  localparam int LW    = $clog2(RATIO);
  localparam int AW    = $clog2(DEPTHB);
  localparam int CW    = AW + 1;

  (* ram_style = RAM_STYLE *) logic [WIDTHB:0] mem [DEPTHB];

  logic [LW-1:0]     lane;
  logic [WIDTHB-1:0] asm_q;
  logic [WIDTHB-1:0] merged;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              in_fire;
  logic              complete;
  logic              out_fire;
  logic              rd_issue;
  logic              s2_load;
  logic [1:0]        occ;
  logic              s1_v;
  logic [WIDTHB:0]   s1_d;
  logic              out_v_q;
  logic              out_last_q;
  logic [WIDTHB-1:0] out_data_q;

  assign bus.in_ready  = (count < CW'(DEPTHB));
  assign bus.out_valid = out_v_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign complete = in_fire & (bus.in_last | (lane == LW'(RATIO - 1)));
  assign out_fire = out_v_q & bus.out_ready;

  // The assembly register is cleared on every completion, so lanes above the
  // current one are already zero when an in_last flush closes a short word.
  always_comb begin
    merged = asm_q;
    merged[lane*WIDTHA +: WIDTHA] = bus.in_data;
  end

  assign occ      = {1'b0, s1_v} + {1'b0, out_v_q} - {1'b0, out_fire};
  assign rd_issue = (count != '0) && (occ < 2'd2);
  assign s2_load  = s1_v & (~out_v_q | bus.out_ready);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      lane  <= '0;
      asm_q <= '0;
    end else if (in_fire) begin
      if (complete) begin
        lane  <= '0;
        asm_q <= '0;
      end else begin
        lane  <= lane + LW'(1);
        asm_q <= merged;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (complete) wr_ptr <= wr_ptr + AW'(1);
      if (rd_issue) rd_ptr <= rd_ptr + AW'(1);
      case ({complete, rd_issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Full count blocks writes and empty count blocks reads, so the same
  // address is never written and read on one edge.
  always_ff @(posedge ap_clk) begin
    if (complete) mem[wr_ptr] <= {bus.in_last, merged};
    if (rd_issue) s1_d <= mem[rd_ptr];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_v       <= 1'b0;
      out_v_q    <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (rd_issue)     s1_v <= 1'b1;
      else if (s2_load) s1_v <= 1'b0;

      if (s2_load) begin
        out_v_q    <= 1'b1;
        out_last_q <= s1_d[WIDTHB];
        out_data_q <= s1_d[WIDTHB-1:0];
      end else if (out_fire) begin
        out_v_q <= 1'b0;
      end
    end
  end
endmodule
